// File: rtl/mult_arb_seq.sv
// mult_arb_seq
// Round-robin arbiter and sequencer that shares one shift-add multiplier
// datapath among NREQ requesters. The block grants the datapath to one
// requester at a time. It then steps that requester's operands through a
// full WIDTH-iteration multiply (load, then check/add/shift per bit) and
// pulses done back to the owner when the multiply is finished.
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   i_req            per-requester level request, held until its done pulse
//   o_grant          one-hot owner of the datapath, all-zero when idle
//   o_sel            binary index of the current/last owner (steers muxes)
//   o_done           one-cycle completion pulse to the owner
//   o_busy           high from LOAD through DONE
//   i_q0             multiplier LSB fed back from the datapath
//   o_load_registers load operands and clear the accumulator
//   o_add            accumulator += multiplicand this cycle
//   o_shift          shift accumulator/multiplier right this cycle
module mult_arb_seq #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           i_req,
    output logic [NREQ-1:0]           o_grant,
    output logic [$clog2(NREQ)-1:0]   o_sel,
    output logic [NREQ-1:0]           o_done,
    output logic                      o_busy,
    input  logic                      i_q0,
    output logic                      o_load_registers,
    output logic                      o_add,
    output logic                      o_shift
);

    localparam int SELW = $clog2(NREQ);
    localparam int CNTW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [SELW-1:0]   r_sel;
    logic [NREQ-1:0]   r_grant;
    logic [CNTW-1:0]   r_count;
    logic [SELW-1:0]   w_winner;

    // State register; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. The counter holds the number of shifts still to
    // do, so the last shift is the one that sees a count of 1. The counter
    // therefore never wraps below zero. Unused encodings fall back to IDLE.
    always_comb begin
        w_nextState = IDLE;
        case (r_state)
            IDLE:    w_nextState = (|i_req) ? LOAD : IDLE;
            LOAD:    w_nextState = CHECK;
            CHECK:   w_nextState = i_q0 ? ADD : SHIFT;
            ADD:     w_nextState = SHIFT;
            SHIFT:   w_nextState = (r_count == CNTW'(1)) ? DONE : CHECK;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Round-robin search: scan upward from the last owner + 1 with wrap.
    // The last owner's index (r_sel) doubles as the rotation pointer, so
    // the block needs no separate pointer register. That index resets to
    // NREQ-1, so requester 0 has first priority after reset.
    always_comb begin
        int   idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        w_winner = r_sel;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(r_sel) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && i_req[idx]) begin
                found    = 1'b1;
                w_winner = SELW'(idx);
            end
        end
    end

    // Ownership and iteration count. The grant and select registers are
    // captured only at the IDLE->LOAD edge, so requests that change
    // mid-operation cannot disturb the current owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel   <= SELW'(NREQ - 1);
            r_grant <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|i_req) begin
                        r_sel   <= w_winner;
                        r_grant <= NREQ'(1) << w_winner;
                    end
                end
                LOAD:    r_count <= CNTW'(WIDTH);
                SHIFT:   r_count <= r_count - CNTW'(1);
                DONE:    r_grant <= '0;
                CHECK, ADD: ;
                default: r_grant <= '0;
            endcase
        end
    end

    // Moore output decode from the registered state only.
    always_comb begin
        o_load_registers = 1'b0;
        o_add            = 1'b0;
        o_shift          = 1'b0;
        o_busy           = 1'b0;
        o_done           = '0;
        case (r_state)
            LOAD: begin
                o_load_registers = 1'b1;
                o_busy           = 1'b1;
            end
            CHECK: o_busy = 1'b1;
            ADD: begin
                o_add  = 1'b1;
                o_busy = 1'b1;
            end
            SHIFT: begin
                o_shift = 1'b1;
                o_busy  = 1'b1;
            end
            DONE: begin
                o_done = NREQ'(1) << r_sel;
                o_busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_grant = r_grant;
    assign o_sel   = r_sel;

endmodule

// File: tb/tb_mult_arb_seq.sv
// tb_mult_arb_seq
// Scoreboard bench for mult_arb_seq (NREQ=4, WIDTH=8). A small behavioural
// multiplier register answers load/shift and feeds its LSB back as q0.
// Stimulus pushes the expected owner, latency and add count for every
// operation. A negedge monitor pops one entry per done pulse and compares
// it with what it observed.
module tb_mult_arb_seq;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic [3:0] done;
    logic       busy;
    logic       q0;
    logic       loadRegs;
    logic       add;
    logic       shift;

    typedef struct {
        int idx;
        int lat;
        int adds;
    } exp_t;

    exp_t       sb[$];
    int         compareCount = 0;
    int         errorCount   = 0;
    int         cyc          = 0;
    int         loadCyc      = 0;
    int         addCnt       = 0;
    int         shiftCnt     = 0;
    logic [3:0] loadGrant    = '0;
    logic [7:0] mult [4];
    logic [7:0] mreg         = '0;

    mult_arb_seq #(.NREQ(4), .WIDTH(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_req            (req),
        .o_grant          (grant),
        .o_sel            (sel),
        .o_done           (done),
        .o_busy           (busy),
        .i_q0             (q0),
        .o_load_registers (loadRegs),
        .o_add            (add),
        .o_shift          (shift)
    );

    // Free-running clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: the multiplier register is loaded from the owner's
    // operand and shifted right; its LSB is the q0 feedback.
    always @(posedge clk) begin
        if (loadRegs) begin
            mreg <= mult[sel];
        end else if (shift) begin
            mreg <= mreg >> 1;
        end
    end
    assign q0 = mreg[0];

    // Shared comparison helper used by both stimulus and monitor.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compareCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: tracks each operation from LOAD and scores it on done.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("grantVsBusy", {28'd0, grant}, busy ? (32'd1 << sel) : 32'd0);
            if (loadRegs) begin
                loadCyc   = cyc;
                addCnt    = 0;
                shiftCnt  = 0;
                loadGrant = grant;
            end
            if (add)   addCnt++;
            if (shift) shiftCnt++;
            if (done != 4'b0) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpectedDone", {28'd0, done}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("doneVec",    {28'd0, done},      32'd1 << e.idx);
                    checkOutput("doneSel",    {30'd0, sel},       e.idx);
                    checkOutput("loadGrant",  {28'd0, loadGrant}, 32'd1 << e.idx);
                    checkOutput("latency",    cyc - loadCyc + 1,  e.lat);
                    checkOutput("addCount",   addCnt,             e.adds);
                    checkOutput("shiftCount", shiftCnt,           8);
                end
            end
        end
    end

    task automatic expectOp(input int idx, input int lat, input int adds);
        sb.push_back('{idx, lat, adds});
    endtask

    // Set the operand, record the expectation, raise the request.
    task automatic applyStimulus(input int idx, input logic [7:0] m, input int lat, input int adds);
        mult[idx] = m;
        expectOp(idx, lat, adds);
        req[idx] = 1'b1;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        #1;
        checkOutput("rstGrant", {28'd0, grant}, 32'd0);
        checkOutput("rstSel",   {30'd0, sel},   32'd3);
        checkOutput("rstDone",  {28'd0, done},  32'd0);
        checkOutput("rstCtl",   {28'd0, busy, loadRegs, add, shift}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic waitDone(input int idx, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[idx] && n < budget);
        if (!done[idx]) checkOutput("doneTimeout", 32'd0, 32'd1);
    endtask

    task automatic waitAnyDone(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == 4'b0 && n < budget);
        if (done == 4'b0) checkOutput("anyDoneTimeout", 32'd0, 32'd1);
    endtask

    task automatic waitSignal(input int which, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(which == 0 ? loadRegs : add) && n < budget);
        if (!(which == 0 ? loadRegs : add)) checkOutput("ctlTimeout", 32'd0, 32'd1);
    endtask

    // Hard stop in case something outside the bounded waits stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b1;
        req   = '0;
        for (int i = 0; i < 4; i++) mult[i] = '0;

        // Single request, multiplier 0x05: 2+16+2 = 20 cycles, 2 adds.
        applyReset();
        applyStimulus(0, 8'h05, 20, 2);
        waitDone(0, 40);
        req[0] = 1'b0;
        @(negedge clk);
        checkOutput("grantAfterDone", {28'd0, grant}, 32'd0);
        checkOutput("busyAfterDone",  {31'd0, busy},  32'd0);

        // All four requesting continuously: order 0,1,2,3,0.
        // 0x00 -> 18, 0xFF -> 26 (8 adds), 0x81 -> 20, 0x10 -> 19.
        applyReset();
        applyStimulus(0, 8'h00, 18, 0);
        applyStimulus(1, 8'hFF, 26, 8);
        applyStimulus(2, 8'h81, 20, 2);
        applyStimulus(3, 8'h10, 19, 1);
        expectOp(0, 18, 0);
        for (int k = 0; k < 5; k++) waitAnyDone(40);
        req = '0;
        repeat (2) @(negedge clk);

        // Reset during ADD aborts the operation with no done.
        applyReset();
        mult[1] = 8'hFF;
        req[1]  = 1'b1;
        waitSignal(1, 20);
        rst_n = 1'b0;
        req   = '0;
        #1;
        checkOutput("abortGrant", {28'd0, grant}, 32'd0);
        checkOutput("abortSel",   {30'd0, sel},   32'd3);
        checkOutput("abortDone",  {28'd0, done},  32'd0);
        checkOutput("abortCtl",   {28'd0, busy, loadRegs, add, shift}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(2, 8'h03, 20, 2);
        @(negedge clk);
        checkOutput("grantReq2", {28'd0, grant}, 32'h4);
        waitDone(2, 40);
        req[2] = 1'b0;
        repeat (2) @(negedge clk);

        // req[1] dropped mid-operation: still completes (0x0A -> 20, 2 adds).
        applyStimulus(1, 8'h0A, 20, 2);
        waitSignal(0, 10);
        repeat (3) @(negedge clk);
        req[1] = 1'b0;
        waitDone(1, 40);
        repeat (3) @(negedge clk);
        checkOutput("idleAfterDrop", {31'd0, busy}, 32'd0);

        // Lone req[3] re-granted after one IDLE cycle; req[0] wins next.
        applyStimulus(3, 8'h01, 19, 1);
        expectOp(3, 19, 1);
        waitDone(3, 40);
        @(negedge clk);
        checkOutput("gapBusy",  {31'd0, busy},  32'd0);
        checkOutput("gapGrant", {28'd0, grant}, 32'd0);
        @(negedge clk);
        checkOutput("regrantLoad",  {31'd0, loadRegs}, 32'd1);
        checkOutput("regrantGrant", {28'd0, grant},    32'h8);
        repeat (4) @(negedge clk);
        applyStimulus(0, 8'h00, 18, 0);
        waitDone(3, 40);
        req[3] = 1'b0;
        @(negedge clk);
        checkOutput("idleBeforeReq0", {31'd0, busy}, 32'd0);
        @(negedge clk);
        checkOutput("grantReq0", {28'd0, grant}, 32'h1);
        waitDone(0, 40);
        req[0] = 1'b0;
        repeat (4) @(negedge clk);

        checkOutput("scoreboardEmpty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
        $finish;
    end

endmodule
